// File: rtl/seq_pkg.sv
// Shared encodings, instruction layout and control bundle for the control sequencer.
package seq_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned IMM_W    = 13;
  localparam int unsigned FS_W     = 5;
  localparam int unsigned STATUS_W = 4;
  localparam int unsigned BR_W     = 8;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_LSB  = 23;
  localparam int unsigned RN_LSB  = 18;
  localparam int unsigned RM_LSB  = 13;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_SHR   = 4'd3;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'd4;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd5;
  localparam logic [OP_W-1:0] OP_STORE = 4'd6;
  localparam logic [OP_W-1:0] OP_BZ    = 4'd7;
  localparam logic [OP_W-1:0] OP_HALT  = 4'd15;

  localparam logic [FS_W-1:0] FS_ADD = 5'b10000;
  localparam logic [FS_W-1:0] FS_SUB = 5'b10010;
  localparam logic [FS_W-1:0] FS_SHR = 5'b10100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef struct packed {
    logic [FS_W-1:0] sel;
    logic            cin;
    logic            mux_sel;
    logic            needs_mem;
    logic            needs_wb;
    logic            is_branch;
    logic            is_halt;
  } dec_t;

  // Everything the sequencer drives toward the datapath and fetch port
  typedef struct packed {
    logic              instr_req;
    logic              write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  read_a;
    logic [REG_W-1:0]  read_b;
    logic [FS_W-1:0]   sel;
    logic              mux_sel;
    logic              cin;
    logic [DATA_W-1:0] const_out;
    logic              write_ram;
    logic              busy;
    logic              halted;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Opcode to datapath-control decode; purely combinational.
module instr_decode
  import seq_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output dec_t            dec_c_o
);

  always_comb begin
    dec_c_o = '0;
    case (op_i)
      OP_ADD: begin
        dec_c_o.sel      = FS_ADD;
        dec_c_o.needs_wb = 1'b1;
      end
      OP_SUB: begin
        dec_c_o.sel      = FS_SUB;
        dec_c_o.cin      = 1'b1;
        dec_c_o.needs_wb = 1'b1;
      end
      OP_SHR: begin
        dec_c_o.sel      = FS_SHR;
        dec_c_o.needs_wb = 1'b1;
      end
      OP_ADDI: begin
        dec_c_o.sel      = FS_ADD;
        dec_c_o.mux_sel  = 1'b1;
        dec_c_o.needs_wb = 1'b1;
      end
      OP_LOAD: begin
        dec_c_o.sel       = FS_ADD;
        dec_c_o.mux_sel   = 1'b1;
        dec_c_o.needs_mem = 1'b1;
        dec_c_o.needs_wb  = 1'b1;
      end
      OP_STORE: begin
        dec_c_o.sel       = FS_ADD;
        dec_c_o.mux_sel   = 1'b1;
        dec_c_o.needs_mem = 1'b1;
      end
      // rn is passed through the adder (+0) so Z reports rn == 0
      OP_BZ: begin
        dec_c_o.sel       = FS_ADD;
        dec_c_o.mux_sel   = 1'b1;
        dec_c_o.is_branch = 1'b1;
      end
      OP_HALT: dec_c_o.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the alu_reg_ram datapath.
// Owns the pc, the latched instruction and the write-back result register.
module control_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [PC_W-1:0]     instrAddr,
  output logic                instrReq,
  input  logic [INSTR_W-1:0]  instrData,
  input  logic                instrValid,
  input  logic [DATA_W-1:0]   aluOut,
  input  logic [STATUS_W-1:0] status,
  input  logic [DATA_W-1:0]   ramOut,
  output logic                write,
  output logic [REG_W-1:0]    writeReg,
  output logic [DATA_W-1:0]   data,
  output logic [REG_W-1:0]    readA,
  output logic [REG_W-1:0]    readB,
  output logic [FS_W-1:0]     sel,
  output logic                muxSel,
  output logic                cin,
  output logic [DATA_W-1:0]   constOut,
  output logic                writeRam,
  output logic                busy,
  output logic                halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zflag_q, zflag_d;
  ctrl_t             ctrl_q, ctrl_d;
  dec_t              dec;

  // Only Z participates in sequencing; V/C/N belong to the datapath
  logic unused_flags;
  assign unused_flags = ^status[STATUS_W-1:1];

  instr_decode u_decode (
    .op_i    (instr_q.op),
    .dec_c_o (dec)
  );

  // State register and all sequencer flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      result_q <= '0;
      zflag_q  <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      zflag_q  <= zflag_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Next-state, pc and result sequencing
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    result_d = result_q;
    zflag_d  = zflag_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instrValid) begin
          instr_d = instrData;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = dec.is_halt ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        result_d = aluOut;
        zflag_d  = status[0];
        if (dec.is_branch && zflag_d) begin
          pc_d = pc_q + PC_W'($signed(instr_q.imm[BR_W-1:0]));
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
        if (dec.needs_mem)     state_d = S_MEM;
        else if (dec.needs_wb) state_d = S_WB;
        else                   state_d = S_FETCH;
      end
      S_MEM: begin
        if (instr_q.op == OP_LOAD) result_d = ramOut;
        state_d = dec.needs_wb ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs computed from the upcoming state so they register cleanly.
  // When state_d is EXEC/MEM the instruction is stable, so decoding instr_q is valid.
  always_comb begin
    ctrl_d           = '0;
    ctrl_d.instr_req = (state_d == S_FETCH);
    ctrl_d.busy      = (state_d != S_IDLE) && (state_d != S_HALTED);
    ctrl_d.halted    = (state_d == S_HALTED);
    if (state_d inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ctrl_d.read_a = instr_d.rn;
      ctrl_d.read_b = instr_d.rm;
    end
    if (state_d inside {S_EXEC, S_MEM}) begin
      ctrl_d.sel       = dec.sel;
      ctrl_d.cin       = dec.cin;
      ctrl_d.mux_sel   = dec.mux_sel;
      ctrl_d.const_out = dec.is_branch ? '0 : DATA_W'(instr_d.imm);
    end
    ctrl_d.write_ram = (state_d == S_MEM) && (instr_d.op == OP_STORE);
    if ((state_d == S_WB) && (instr_d.rd != XZR)) begin
      ctrl_d.write     = 1'b1;
      ctrl_d.write_reg = instr_d.rd;
      ctrl_d.data      = result_d;
    end
  end

  assign instrAddr = pc_q;
  assign instrReq  = ctrl_q.instr_req;
  assign write     = ctrl_q.write;
  assign writeReg  = ctrl_q.write_reg;
  assign data      = ctrl_q.data;
  assign readA     = ctrl_q.read_a;
  assign readB     = ctrl_q.read_b;
  assign sel       = ctrl_q.sel;
  assign muxSel    = ctrl_q.mux_sel;
  assign cin       = ctrl_q.cin;
  assign constOut  = ctrl_q.const_out;
  assign writeRam  = ctrl_q.write_ram;
  assign busy      = ctrl_q.busy;
  assign halted    = ctrl_q.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: datapath stand-in plus ISA reference scoreboard.
module tb_control_sequencer;
  import seq_pkg::*;

  localparam int unsigned PC_W = 8;

  logic              clock;
  logic              reset;
  logic              start;
  logic [PC_W-1:0]   instrAddr;
  logic              instrReq;
  logic [31:0]       instrData;
  logic              instrValid;
  logic [63:0]       aluOut;
  logic [3:0]        status;
  logic [63:0]       ramOut;
  logic              write;
  logic [4:0]        writeReg;
  logic [63:0]       data;
  logic [4:0]        readA;
  logic [4:0]        readB;
  logic [4:0]        sel;
  logic              muxSel;
  logic              cin;
  logic [63:0]       constOut;
  logic              writeRam;
  logic              busy;
  logic              halted;

  control_sequencer #(.PC_W(PC_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .instrAddr  (instrAddr),
    .instrReq   (instrReq),
    .instrData  (instrData),
    .instrValid (instrValid),
    .aluOut     (aluOut),
    .status     (status),
    .ramOut     (ramOut),
    .write      (write),
    .writeReg   (writeReg),
    .data       (data),
    .readA      (readA),
    .readB      (readB),
    .sel        (sel),
    .muxSel     (muxSel),
    .cin        (cin),
    .constOut   (constOut),
    .writeRam   (writeRam),
    .busy       (busy),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Datapath stand-in: register file, ALU and RAM reacting to the DUT's controls
  logic [63:0] dp_regs [32];
  logic [63:0] dp_ram  [256];
  logic [63:0] op_a, op_b;

  always_comb begin
    op_a = dp_regs[readA];
    op_b = muxSel ? constOut : dp_regs[readB];
    case (sel)
      FS_ADD:  aluOut = op_a + op_b + 64'(cin);
      FS_SUB:  aluOut = op_a + ~op_b + 64'(cin);
      FS_SHR:  aluOut = op_a >> 1;
      default: aluOut = '0;
    endcase
    status = {3'b000, aluOut == 64'd0};
    ramOut = dp_ram[aluOut[7:0]];
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)  dp_regs[i] <= '0;
      for (int i = 0; i < 256; i++) dp_ram[i]  <= '0;
    end else begin
      if (write)    dp_regs[writeReg]  <= data;
      if (writeRam) dp_ram[aluOut[7:0]] <= dp_regs[readB];
    end
  end

  // Scoreboard queues, filled from the ISA reference when an instruction is handed over
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] val;
    int          cyc;
  } wr_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] val;
    logic [63:0] imm;
    int          cyc;
  } st_exp_t;

  wr_exp_t wq[$];
  st_exp_t sq[$];
  wr_exp_t m_w;
  st_exp_t m_s;

  always @(negedge clock) begin
    if (reset) begin
      if (write) begin
        check_eq("wr_excl", 64'(writeRam), 64'd0);
        if (wq.size() == 0) begin
          check_eq("wr_unexpected", 64'(wq.size()), 64'd1);
        end else begin
          m_w = wq.pop_front();
          check_eq("wr_reg", 64'(writeReg), 64'(m_w.rd));
          check_eq("wr_data", data, m_w.val);
          check_eq("wr_cycle", 64'(cyc), 64'(m_w.cyc));
        end
      end
      if (writeRam) begin
        if (sq.size() == 0) begin
          check_eq("st_unexpected", 64'(sq.size()), 64'd1);
        end else begin
          m_s = sq.pop_front();
          check_eq("st_sel", 64'(sel), 64'(FS_ADD));
          check_eq("st_muxsel", 64'(muxSel), 64'd1);
          check_eq("st_const", constOut, m_s.imm);
          check_eq("st_addr", 64'(aluOut[7:0]), 64'(m_s.addr));
          check_eq("st_data", dp_regs[readB], m_s.val);
          check_eq("st_cycle", 64'(cyc), 64'(m_s.cyc));
        end
      end
    end
  end

  // ISA-level reference
  logic [63:0] ref_regs [32];
  logic [63:0] ref_ram  [256];
  int prev_a;
  int prev_lat;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rn, input logic [4:0] rm,
                                      input logic [12:0] imm);
    return {op, rd, rn, rm, imm};
  endfunction

  task automatic run_instr(input int exp_pc, input logic [31:0] ins, input int dly,
                           input bit stray, input bit commit);
    int          waited;
    int          a;
    int          lat;
    bit          wb;
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [12:0] imm;
    logic [63:0] va, vb, res;
    logic [7:0]  addr;
    waited = 0;
    while (!instrReq && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!instrReq) begin
      check_eq("fetch_timeout", 64'(instrReq), 64'd1);
      return;
    end
    if (prev_a >= 0) check_eq("fetch_latency", 64'(cyc - prev_a), 64'(prev_lat));
    check_eq("fetch_pc", 64'(instrAddr), 64'(exp_pc));
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      check_eq("req_hold", 64'({instrReq, instrAddr}), 64'({1'b1, 8'(exp_pc)}));
    end
    instrValid = 1'b1;
    instrData  = ins;
    @(posedge clock);
    @(negedge clock);
    instrValid = 1'b0;
    instrData  = $urandom;
    a = cyc;

    op  = ins[31:28];
    rd  = ins[27:23];
    rn  = ins[22:18];
    rm  = ins[17:13];
    imm = ins[12:0];
    va  = (rn == 5'd31) ? 64'd0 : ref_regs[rn];
    vb  = (rm == 5'd31) ? 64'd0 : ref_regs[rm];
    res = '0;
    wb  = 1'b0;
    lat = 2;
    addr = 8'(va + 64'(imm));
    case (op)
      OP_ADD:   begin res = va + vb;         wb = 1'b1; lat = 3; end
      OP_SUB:   begin res = va - vb;         wb = 1'b1; lat = 3; end
      OP_SHR:   begin res = va >> 1;         wb = 1'b1; lat = 3; end
      OP_ADDI:  begin res = va + 64'(imm);   wb = 1'b1; lat = 3; end
      OP_LOAD:  begin res = ref_ram[addr];   wb = 1'b1; lat = 4; end
      OP_STORE: begin
        lat = 3;
        if (commit) begin
          ref_ram[addr] = vb;
          sq.push_back('{addr: addr, val: vb, imm: 64'(imm), cyc: a + 2});
        end
      end
      default: ;
    endcase
    if (commit && wb && rd != 5'd31) begin
      ref_regs[rd] = res;
      wq.push_back('{rd: rd, val: res, cyc: a + lat - 1});
    end
    prev_a   = a;
    prev_lat = lat;

    if (stray) begin
      @(negedge clock);
      @(negedge clock);
      instrValid = 1'b1;
      instrData  = enc(OP_ADD, 5'd9, 5'd1, 5'd1, 13'd0);
      @(negedge clock);
      instrValid = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int reqs;
    reset      = 1'b0;
    start      = 1'b0;
    instrValid = 1'b0;
    instrData  = '0;
    prev_a     = -1;
    prev_lat   = 0;
    for (int i = 0; i < 32; i++)  ref_regs[i] = '0;
    for (int i = 0; i < 256; i++) ref_ram[i]  = '0;

    repeat (3) @(negedge clock);
    check_eq("rst_ctrl", 64'({instrAddr, instrReq, write, writeReg, readA, readB, sel,
                              muxSel, cin, writeRam, busy, halted}), 64'd0);
    check_eq("rst_data", data, 64'd0);
    check_eq("rst_const", constOut, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("idle_wait", 64'({busy, instrReq}), 64'd0);
    start = 1'b1;

    // Reset while an ADD is in EXEC
    run_instr(0, enc(OP_ADD, 5'd2, 5'd1, 5'd1, 13'd0), 0, 1'b0, 1'b0);
    @(negedge clock);
    check_eq("exec_ctrl", 64'({readA, readB, sel, busy}), 64'({5'd1, 5'd1, FS_ADD, 1'b1}));
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_ctrl", 64'({instrAddr, instrReq, write, writeReg, readA, readB, sel,
                                 muxSel, cin, writeRam, busy, halted}), 64'd0);
    check_eq("midrst_const", constOut, 64'd0);
    @(negedge clock);
    @(negedge clock);
    check_eq("midrst_nowrite", 64'({write, writeRam, busy}), 64'd0);
    reset  = 1'b1;
    prev_a = -1;

    run_instr(0,   enc(OP_ADDI,  5'd1, 5'd31, 5'd0, 13'd14),    0, 1'b0, 1'b1);
    run_instr(1,   enc(OP_ADD,   5'd2, 5'd1,  5'd1, 13'd0),     0, 1'b0, 1'b1);
    run_instr(2,   enc(OP_STORE, 5'd0, 5'd0,  5'd2, 13'd5),     0, 1'b0, 1'b1);
    run_instr(3,   enc(OP_LOAD,  5'd3, 5'd0,  5'd0, 13'd5),     0, 1'b0, 1'b1);
    run_instr(4,   enc(OP_SUB,   5'd4, 5'd2,  5'd1, 13'd0),     5, 1'b0, 1'b1);
    run_instr(5,   enc(OP_SHR,   5'd5, 5'd2,  5'd0, 13'd0),     0, 1'b0, 1'b1);
    run_instr(6,   enc(OP_BZ,    5'd0, 5'd0,  5'd0, 13'h004),   0, 1'b0, 1'b1);
    run_instr(10,  enc(OP_BZ,    5'd0, 5'd0,  5'd0, 13'h0FC),   0, 1'b0, 1'b1);
    run_instr(6,   enc(OP_BZ,    5'd0, 5'd0,  5'd0, 13'h004),   0, 1'b0, 1'b1);
    run_instr(10,  enc(OP_BZ,    5'd0, 5'd1,  5'd0, 13'h0FC),   0, 1'b0, 1'b1);
    run_instr(11,  enc(OP_BZ,    5'd0, 5'd0,  5'd0, 13'h07F),   0, 1'b0, 1'b1);
    run_instr(138, enc(OP_BZ,    5'd0, 5'd0,  5'd0, 13'h03E),   0, 1'b0, 1'b1);
    run_instr(200, enc(OP_BZ,    5'd0, 5'd0,  5'd0, 13'h07F),   0, 1'b0, 1'b1);
    run_instr(71,  enc(OP_ADD,   5'd7, 5'd2,  5'd4, 13'd0),     0, 1'b1, 1'b1);
    run_instr(72,  enc(OP_NOP,   5'd0, 5'd0,  5'd0, 13'd0),     0, 1'b0, 1'b1);
    run_instr(73,  enc(OP_ADD,   5'd31, 5'd1, 5'd1, 13'd0),     0, 1'b0, 1'b1);
    run_instr(74,  enc(OP_HALT,  5'd0, 5'd0,  5'd0, 13'd0),     0, 1'b0, 1'b1);

    @(negedge clock);
    check_eq("halt_flags", 64'({halted, busy}), 64'({1'b1, 1'b0}));
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (instrReq) reqs++;
    end
    check_eq("halt_noreq", 64'(reqs), 64'd0);
    check_eq("halt_pc", 64'(instrAddr), 64'd74);
    check_eq("halt_hold", 64'(halted), 64'd1);
    check_eq("wq_drained", 64'(wq.size()), 64'd0);
    check_eq("sq_drained", 64'(sq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
